rule_engine: RTL

RULE_ENGINE -- requirements
Module: rule_engine

---
 rtl/fuzzy_pkg.sv | 12 +
 rtl/mu_minmax.sv | 12 +
 rtl/rule_engine.sv | 87 ++++++++
 3 files changed

// File: rtl/fuzzy_pkg.sv
// fuzzy_pkg: shared FSM states, consequent codes and the default rule table for rule_engine
package fuzzy_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;
    localparam logic [1:0] CONS_NEG  = 2'd0;
    localparam logic [1:0] CONS_ZERO = 2'd1;
    localparam logic [1:0] CONS_POS  = 2'd2;
    localparam logic [1:0] CONS_OFF  = 2'd3;
    localparam int N_RULES = 9;
    localparam logic [15:0] MU_ONE = 16'h8000;
    // rule k = i*3+j: i+j<2 -> NEG, anti-diagonal i+j==2 -> ZERO, i+j>2 -> POS
    localparam logic [17:0] DEFAULT_RULES = 18'b10_10_01_10_01_00_01_00_00;
endpackage

// File: rtl/mu_minmax.sv
// mu_minmax: combinational unsigned min and max of two membership values
module mu_minmax #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] mn,
    output logic [W-1:0] mx
);
    assign mn = a < b ? a : b;
    assign mx = a < b ? b : a;
endmodule

// File: rtl/rule_engine.sv
// rule_engine: evaluates a 3x3 fuzzy rule table one rule per cycle, aggregating max-of-min strengths
module rule_engine
    import fuzzy_pkg::*;
#(
    parameter int MU_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [MU_W-1:0] mu_t_neg,
    input  logic [MU_W-1:0] mu_t_zero,
    input  logic [MU_W-1:0] mu_t_pos,
    input  logic [MU_W-1:0] mu_dt_neg,
    input  logic [MU_W-1:0] mu_dt_zero,
    input  logic [MU_W-1:0] mu_dt_pos,
    input  logic [17:0]     rule_cfg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MU_W-1:0] w_neg,
    output logic [MU_W-1:0] w_zero,
    output logic [MU_W-1:0] w_pos
);
    localparam logic [MU_W-1:0] ONE = MU_W'(MU_ONE);
    state_t state;
    logic [3:0] k;
    logic [MU_W-1:0] mt [3];
    logic [MU_W-1:0] md [3];
    logic [17:0] cfg;
    logic [MU_W-1:0] acc_neg, acc_zero, acc_pos, n_neg, n_zero, n_pos;
    logic [MU_W-1:0] acc_sel, strength, upd, unused_mx, unused_mn;
    logic [1:0] ti, dj, code;
    function automatic logic [MU_W-1:0] clamp(input logic [MU_W-1:0] m);
        return m > ONE ? ONE : m;
    endfunction
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_comb begin
        ti      = k >= 4'd6 ? 2'd2 : k >= 4'd3 ? 2'd1 : 2'd0;
        dj      = 2'(k - 4'(ti) * 4'd3);
        code    = cfg[{k, 1'b0} +: 2];
        acc_sel = code == CONS_NEG ? acc_neg : code == CONS_ZERO ? acc_zero : acc_pos;
        n_neg   = code == CONS_NEG  ? upd : acc_neg;
        n_zero  = code == CONS_ZERO ? upd : acc_zero;
        n_pos   = code == CONS_POS  ? upd : acc_pos;
    end
    mu_minmax #(.W(MU_W)) u_strength (.a(mt[ti]), .b(md[dj]), .mn(strength), .mx(unused_mx));
    mu_minmax #(.W(MU_W)) u_aggregate (.a(acc_sel), .b(strength), .mn(unused_mn), .mx(upd));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            mt       <= '{default: '0};
            md       <= '{default: '0};
            cfg      <= '0;
            acc_neg  <= '0;
            acc_zero <= '0;
            acc_pos  <= '0;
            w_neg    <= '0;
            w_zero   <= '0;
            w_pos    <= '0;
        end else if (state == IDLE && in_valid) begin
            mt       <= '{clamp(mu_t_neg), clamp(mu_t_zero), clamp(mu_t_pos)};
            md       <= '{clamp(mu_dt_neg), clamp(mu_dt_zero), clamp(mu_dt_pos)};
            cfg      <= rule_cfg;
            acc_neg  <= '0;
            acc_zero <= '0;
            acc_pos  <= '0;
            k        <= '0;
            state    <= EVAL;
        end else if (state == EVAL) begin
            acc_neg  <= n_neg;
            acc_zero <= n_zero;
            acc_pos  <= n_pos;
            k        <= k + 4'd1;
            // the last rule's update is folded straight into the outputs on DONE entry
            if (k == 4'(N_RULES - 1)) begin
                w_neg  <= n_neg;
                w_zero <= n_zero;
                w_pos  <= n_pos;
                state  <= DONE;
            end
        end else if (state == DONE && out_ready) begin
            state <= IDLE;
        end
    end
endmodule
